// File: rtl/note_pkg.sv
// note_pkg: shared FSM state, song entry type, rest code, song table and note decoding
package note_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, PLAY, PAUSE, DONE} state_t;

  // widest hold field the table carries; HOLD_W may use up to this many bits
  localparam int HOLD_MAX = 8;

  typedef struct packed {
    logic [3:0]          code;
    logic [HOLD_MAX-1:0] hold;
  } entry_t;

  localparam logic [3:0] REST = 4'd15;
  localparam entry_t REST_ENTRY = '{code: REST, hold: 8'd1};

  // built-in song; indices past the table read as a one-beat rest
  localparam entry_t SONG [16] = '{
    '{4'd0, 8'd2}, '{4'd4, 8'd1}, '{4'd15, 8'd1}, '{4'd7, 8'd2},
    '{4'd4, 8'd1}, '{4'd0, 8'd3}, '{4'd2, 8'd1}, '{4'd4, 8'd1},
    '{4'd5, 8'd0}, '{4'd7, 8'd4}, '{4'd12, 8'd1}, '{4'd0, 8'd4},
    '{4'd15, 8'd1}, '{4'd15, 8'd1}, '{4'd15, 8'd1}, '{4'd15, 8'd1}
  };

  function automatic entry_t song_entry(input logic [7:0] idx);
    return idx < 8'd16 ? SONG[idx[3:0]] : REST_ENTRY;
  endfunction

  function automatic logic [11:0] code_to_onehot(input logic [3:0] code);
    return code < 4'd12 ? 12'd1 << code : 12'd0;
  endfunction

endpackage

// File: rtl/song_rom.sv
// song_rom: song table with two synchronous read ports, one-cycle latency, read enables
module song_rom
  import note_pkg::*;
#(
  parameter int SONG_LEN = 12,
  parameter int HOLD_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_a,
  input  logic              en_b,
  input  logic [8:0]        addr_a,
  input  logic [8:0]        addr_b,
  output logic [3:0]        code_a,
  output logic [3:0]        code_b,
  output logic [HOLD_W-1:0] hold_a,
  output logic [HOLD_W-1:0] hold_b
);

  entry_t ent_a, ent_b;

  // addresses beyond the song length read as a one-beat rest
  always_comb begin
    ent_a = addr_a < 9'(SONG_LEN) ? song_entry(addr_a[7:0]) : REST_ENTRY;
    ent_b = addr_b < 9'(SONG_LEN) ? song_entry(addr_b[7:0]) : REST_ENTRY;
  end

  // data holds while a port is not enabled so a deferred read survives a pause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_a <= REST;
      code_b <= REST;
      hold_a <= '0;
      hold_b <= '0;
    end else begin
      if (en_a) begin
        code_a <= ent_a.code;
        hold_a <= ent_a.hold[HOLD_W-1:0];
      end
      if (en_b) begin
        code_b <= ent_b.code;
        hold_b <= ent_b.hold[HOLD_W-1:0];
      end
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// note_scheduler: plays the song table one entry per hold period of beat ticks.
// Define NOTE_SCHEDULER_LOOP_EN to wrap to entry 0 at the end instead of stopping in DONE.
module note_scheduler
  import note_pkg::*;
#(
  parameter int SONG_LEN = 12,
  parameter int HOLD_W   = 4
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              start,
  input  logic              pause,
  input  logic              beat_tick,
  output logic [11:0]       curr_note,
  output logic [11:0]       next_note,
  output logic [HOLD_W-1:0] hold_left,
  output logic [7:0]        game_frame,
  output logic              new_note,
  output logic              playing,
  output logic              done
);

`ifdef NOTE_SCHEDULER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  state_t state, state_nx;
  logic              kick, adv, dec, last, end_song, refill, en_a, en_b;
  logic [7:0]        frame_nx;
  logic [8:0]        addr_a, addr_b;
  logic [3:0]        code_a, code_b;
  logic [HOLD_W-1:0] hold_a, hold_b, next_hold, eff_hold;
  logic [11:0]       eff_note;

  function automatic logic [HOLD_W-1:0] fix_hold(input logic [HOLD_W-1:0] h);
    return h == '0 ? HOLD_W'(1) : h;
  endfunction

  song_rom #(.SONG_LEN(SONG_LEN), .HOLD_W(HOLD_W)) u_rom (
    .clk(CLOCK_50), .rst_n(reset_n),
    .en_a(en_a), .en_b(en_b), .addr_a(addr_a), .addr_b(addr_b),
    .code_a(code_a), .code_b(code_b), .hold_a(hold_a), .hold_b(hold_b)
  );

  // event decode: a tick with pause in the same cycle is dropped
  always_comb begin
    kick     = (state == IDLE || state == DONE) && start;
    adv      = state == PLAY && !pause && beat_tick && hold_left == HOLD_W'(1);
    dec      = state == PLAY && !pause && beat_tick && hold_left > HOLD_W'(1);
    last     = game_frame == 8'(SONG_LEN - 1);
    end_song = adv && last && !LOOP;
    frame_nx = (LOOP && last) ? 8'd0 : game_frame + 8'd1;
    eff_note = refill ? code_to_onehot(code_b) : next_note;
    eff_hold = refill ? fix_hold(hold_b) : next_hold;
    en_a     = kick;
    en_b     = kick || adv;
    addr_a   = 9'd0;
    addr_b   = kick ? 9'd1 : (LOOP && frame_nx == 8'(SONG_LEN - 1)) ? 9'd0 : {1'b0, frame_nx} + 9'd1;
  end

  // state register
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = start ? FETCH : state;
      FETCH:      state_nx = PLAY;
      PLAY:       state_nx = pause ? PAUSE : end_song ? DONE : PLAY;
      PAUSE:      state_nx = pause ? PLAY : PAUSE;
      default:    state_nx = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    playing = state == PLAY;
    done    = state == DONE;
  end

  // note datapath: load on fetch, advance on the last beat, finish a prefetch one cycle later
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      curr_note  <= '0;
      next_note  <= '0;
      hold_left  <= '0;
      next_hold  <= '0;
      game_frame <= '0;
      new_note   <= 1'b0;
      refill     <= 1'b0;
    end else begin
      new_note <= 1'b0;
      if (kick) begin
        game_frame <= '0;
        curr_note  <= '0;
        next_note  <= '0;
        hold_left  <= '0;
        next_hold  <= '0;
        refill     <= 1'b0;
      end else if (state == FETCH) begin
        curr_note <= code_to_onehot(code_a);
        hold_left <= fix_hold(hold_a);
        next_note <= code_to_onehot(code_b);
        next_hold <= fix_hold(hold_b);
        new_note  <= 1'b1;
      end else if (end_song) begin
        curr_note <= '0;
        next_note <= '0;
        hold_left <= '0;
        refill    <= 1'b0;
      end else if (adv) begin
        curr_note  <= eff_note;
        hold_left  <= eff_hold;
        game_frame <= frame_nx;
        new_note   <= 1'b1;
        refill     <= 1'b1;
      end else if (state == PLAY && !pause) begin
        if (dec) hold_left <= hold_left - HOLD_W'(1);
        if (refill) begin
          next_note <= eff_note;
          next_hold <= eff_hold;
          refill    <= 1'b0;
        end
      end
    end
  end

endmodule
